// File: rtl/clock_set_ctrl_pkg.sv
// rtl/clock_set_ctrl_pkg.sv - shared types and constants for the clock time-set controller
// Purpose: state encoding, BCD field limits and display-select codes used by
//          clock_set_ctrl and its BCD stepper.
// Ports:   none (package).
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_EDIT_HR = 2'd1,
      ST_EDIT_MN = 2'd2,
      ST_COMMIT  = 2'd3
   } state_t;

   localparam logic [7:0] HR_MAX = 8'h23;
   localparam logic [7:0] MN_MAX = 8'h59;

   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_HR   = 2'd1;
   localparam logic [1:0] SEL_MN   = 2'd2;

   function automatic logic is_edit(input state_t s);
      return (s == ST_EDIT_HR) || (s == ST_EDIT_MN);
   endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - key/time inputs and clock-core controls of the time-set controller
// Purpose: bundles the key pulses, current time and the controls sent to the clock core.
// Ports (master drives / slave receives):
//   key_mode, key_up, key_down : 1-cycle key pulses
//   time_in[23:0]              : current time, BCD {hh,mm,ss}
//   run_en, load               : clock core enable / load strobe (slave outputs)
//   data_out[15:0]             : BCD {hh,mm} to load (slave output)
//   sel[1:0], blink            : display highlight and blink phase (slave outputs)
interface clock_set_ctrl_if;
   logic        key_mode;
   logic        key_up;
   logic        key_down;
   logic [23:0] time_in;
   logic        run_en;
   logic        load;
   logic [15:0] data_out;
   logic [1:0]  sel;
   logic        blink;

   modport master (
      output key_mode, key_up, key_down, time_in,
      input  run_en, load, data_out, sel, blink
   );

   modport slave (
      input  key_mode, key_up, key_down, time_in,
      output run_en, load, data_out, sel, blink
   );
endinterface

// File: rtl/clock_set_ctrl_bcd_step.sv
// rtl/clock_set_ctrl_bcd_step.sv - combinational wrapping BCD increment/decrement of one 8-bit field
// Purpose: steps a two-digit BCD value by +/-1 inside 00..max with wrap-around.
// Ports:
//   in[7:0]  : current BCD value
//   max[7:0] : largest legal value (BCD), e.g. 8'h23 or 8'h59
//   up, dn   : step direction; both or neither leave the value unchanged
//   out[7:0] : stepped BCD value
module bcd_step (
   input  logic [7:0] in,
   input  logic [7:0] max,
   input  logic       up,
   input  logic       dn,
   output logic [7:0] out
);

   // For valid BCD the binary ordering matches the decimal ordering, so plain
   // compares against max are enough; an out-of-range value snaps into range.
   always_comb begin
      out = in;
      if (up && !dn) begin
         if (in >= max)
            out = 8'h00;
         else if (in[3:0] >= 4'd9)
            out = {in[7:4] + 4'd1, 4'd0};
         else
            out = in + 8'd1;
      end else if (dn && !up) begin
         if ((in == 8'h00) || (in > max))
            out = max;
         else if (in[3:0] == 4'd0)
            out = {in[7:4] - 4'd1, 4'd9};
         else
            out = in - 8'd1;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - hh:mm time-set controller between key front-end and clock core
// Purpose: edit-mode FSM that freezes the clock, lets hours then minutes be
//          stepped, and issues a single load pulse with the new BCD {hh,mm}.
//          Idle editing times out back to RUN without loading.
// Parameters:
//   TIMEOUT_CYC : idle edit cycles before abort (>=2)
//   BLINK_HALF  : cycles per blink half-period (>=1)
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : clock_set_ctrl_if.slave (keys, time_in in; run_en, load, data_out, sel, blink out)
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int TIMEOUT_CYC = 30_000_000,
   parameter int BLINK_HALF  = 12_500_000
) (
   input logic              clk,
   input logic              rst,
   clock_set_ctrl_if.slave  bus
);

   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_HALF - 1);

   state_t        state, state_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic [BW-1:0] bcnt, bcnt_nxt;
   logic          bph, bph_nxt;
   logic [7:0]    shadow_hr, shadow_hr_nxt;
   logic [7:0]    shadow_mn, shadow_mn_nxt;
   logic [15:0]   data_q, data_nxt;
   logic          run_en_q, load_q, blink_q;
   logic [1:0]    sel_q, sel_nxt;

   logic [7:0]    step_in, step_max, step_out;
   logic          adj;

   // Seconds are never loaded.
   logic          unused_sec;
   assign unused_sec = ^bus.time_in[7:0];

   assign adj = bus.key_up | bus.key_down;

   // One stepper serves whichever field is being edited.
   assign step_in  = (state == ST_EDIT_MN) ? shadow_mn : shadow_hr;
   assign step_max = (state == ST_EDIT_MN) ? MN_MAX    : HR_MAX;

   bcd_step u_step (
      .in  (step_in),
      .max (step_max),
      .up  (bus.key_up),
      .dn  (bus.key_down),
      .out (step_out)
   );

   always_comb begin
      state_nxt     = state;
      tcnt_nxt      = tcnt;
      bcnt_nxt      = bcnt;
      bph_nxt       = bph;
      shadow_hr_nxt = shadow_hr;
      shadow_mn_nxt = shadow_mn;
      data_nxt      = data_q;

      case (state)
         ST_RUN: begin
            if (bus.key_mode) begin
               state_nxt     = ST_EDIT_HR;
               shadow_hr_nxt = bus.time_in[23:16];
               shadow_mn_nxt = bus.time_in[15:8];
               tcnt_nxt      = '0;
               bcnt_nxt      = '0;
               bph_nxt       = 1'b1;
            end
         end

         ST_EDIT_HR, ST_EDIT_MN: begin
            if (bus.key_mode) begin
               // Mode wins over a simultaneous up/down.
               tcnt_nxt = '0;
               bcnt_nxt = '0;
               bph_nxt  = 1'b1;
               if (state == ST_EDIT_HR) begin
                  state_nxt = ST_EDIT_MN;
               end else begin
                  state_nxt = ST_COMMIT;
                  data_nxt  = {shadow_hr, shadow_mn};
               end
            end else if (adj) begin
               // up+down together yields step_out == step_in, but still
               // counts as activity for timeout and blink.
               if (state == ST_EDIT_HR)
                  shadow_hr_nxt = step_out;
               else
                  shadow_mn_nxt = step_out;
               tcnt_nxt = '0;
               bcnt_nxt = '0;
               bph_nxt  = 1'b1;
            end else if (tcnt == T_LAST) begin
               state_nxt = ST_RUN;
               tcnt_nxt  = '0;
               bcnt_nxt  = '0;
               bph_nxt   = 1'b0;
            end else begin
               tcnt_nxt = tcnt + TW'(1);
               if (bcnt == B_LAST) begin
                  bcnt_nxt = '0;
                  bph_nxt  = ~bph;
               end else begin
                  bcnt_nxt = bcnt + BW'(1);
               end
            end
         end

         ST_COMMIT: begin
            state_nxt = ST_RUN;
            tcnt_nxt  = '0;
            bcnt_nxt  = '0;
            bph_nxt   = 1'b0;
         end

         default: state_nxt = ST_RUN;
      endcase

      case (state_nxt)
         ST_EDIT_HR: sel_nxt = SEL_HR;
         ST_EDIT_MN: sel_nxt = SEL_MN;
         default:    sel_nxt = SEL_NONE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state register cycle-for-cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         tcnt      <= '0;
         bcnt      <= '0;
         bph       <= 1'b0;
         shadow_hr <= 8'h00;
         shadow_mn <= 8'h00;
         data_q    <= 16'h0000;
         run_en_q  <= 1'b1;
         load_q    <= 1'b0;
         sel_q     <= SEL_NONE;
         blink_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         tcnt      <= tcnt_nxt;
         bcnt      <= bcnt_nxt;
         bph       <= bph_nxt;
         shadow_hr <= shadow_hr_nxt;
         shadow_mn <= shadow_mn_nxt;
         data_q    <= data_nxt;
         run_en_q  <= (state_nxt == ST_RUN);
         load_q    <= (state_nxt == ST_COMMIT);
         sel_q     <= sel_nxt;
         blink_q   <= is_edit(state_nxt) & bph_nxt;
      end
   end

   assign bus.run_en   = run_en_q;
   assign bus.load     = load_q;
   assign bus.data_out = data_q;
   assign bus.sel      = sel_q;
   assign bus.blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_load = 0;
   int   base;

   always #5 clk = ~clk;

   clock_set_ctrl_if bus ();

   clock_set_ctrl #(
      .TIMEOUT_CYC (20),
      .BLINK_HALF  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(negedge clk) if (bus.load === 1'b1) n_load++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic key(input logic m, input logic u, input logic d);
      bus.key_mode = m;
      bus.key_up   = u;
      bus.key_down = d;
      tick();
      bus.key_mode = 1'b0;
      bus.key_up   = 1'b0;
      bus.key_down = 1'b0;
   endtask

   // Full edit pass: capture t, optional step on hours, optional step on minutes, commit.
   task automatic set_seq(input string tag, input logic [23:0] t,
                          input logic hu, input logic hd, input logic mu, input logic md,
                          input logic [15:0] exp);
      bus.time_in = t;
      key(1'b1, 1'b0, 1'b0);
      if (hu | hd) key(1'b0, hu, hd);
      key(1'b1, 1'b0, 1'b0);
      if (mu | md) key(1'b0, mu, md);
      key(1'b1, 1'b0, 1'b0);
      check(tag, {15'd0, bus.load, bus.data_out}, {15'd0, 1'b1, exp});
      tick();
   endtask

   initial begin
      rst          = 1'b1;
      bus.key_mode = 1'b0;
      bus.key_up   = 1'b0;
      bus.key_down = 1'b0;
      bus.time_in  = 24'h000000;

      // Reset with keys toggling
      for (int i = 0; i < 3; i++) begin
         bus.key_mode = i[0];
         bus.key_up   = ~i[0];
         bus.key_down = i[1];
         tick();
      end
      check("rst_run_en",   bus.run_en,   1);
      check("rst_load",     bus.load,     0);
      check("rst_data",     bus.data_out, 16'h0000);
      check("rst_sel",      bus.sel,      0);
      check("rst_blink",    bus.blink,    0);
      rst = 1'b0;
      bus.key_mode = 1'b0;
      bus.key_up   = 1'b0;
      bus.key_down = 1'b0;
      tick();
      check("rst_keys_dropped", bus.sel, 0);

      // Full set: 12:56 -> hr up x2 -> 14, mn down -> 55
      base = n_load;
      bus.time_in = 24'h125634;
      key(1'b1, 1'b0, 1'b0);
      check("enter_sel",    bus.sel,    1);
      check("enter_run_en", bus.run_en, 0);
      check("enter_blink",  bus.blink,  1);
      check("enter_load",   bus.load,   0);
      bus.time_in = 24'h000000;
      key(1'b0, 1'b1, 1'b0);
      key(1'b0, 1'b1, 1'b0);
      key(1'b1, 1'b0, 1'b0);
      check("mn_sel", bus.sel, 2);
      key(1'b0, 1'b0, 1'b1);
      key(1'b1, 1'b0, 1'b0);
      check("commit_load",   bus.load,     1);
      check("commit_run_en", bus.run_en,   0);
      check("commit_data",   bus.data_out, 16'h1455);
      check("commit_sel",    bus.sel,      0);
      tick();
      check("post_load",   bus.load,     0);
      check("post_run_en", bus.run_en,   1);
      check("post_data",   bus.data_out, 16'h1455);
      check("load_count",  n_load - base, 1);

      // Wrap cases
      set_seq("wrap_23up_59up", 24'h235900, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
      set_seq("wrap_00dn_00dn", 24'h000000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2359);
      set_seq("step_09up",      24'h000900, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010);
      set_seq("step_10dn",      24'h101000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0909);

      // Timeout with no keys, plus blink phases
      base = n_load;
      bus.time_in = 24'h083000;
      key(1'b1, 1'b0, 1'b0);
      check("blink_start", bus.blink, 1);
      idle(3);
      check("blink_hi_end", bus.blink, 1);
      idle(1);
      check("blink_lo", bus.blink, 0);
      idle(4);
      check("blink_hi2", bus.blink, 1);
      idle(11);
      check("to_last_edit", {bus.sel, bus.run_en}, 3'b010);
      idle(1);
      check("to_run", {bus.sel, bus.run_en, bus.load}, 4'b0010);
      check("to_blink", bus.blink, 0);

      // Timeout restarted by a key at cycle 15
      key(1'b1, 1'b0, 1'b0);
      idle(14);
      key(1'b0, 1'b1, 1'b0);
      check("up_blink_restart", bus.blink, 1);
      idle(10);
      check("edit_after_25", bus.sel, 1);
      idle(9);
      check("edit_before_to", bus.sel, 1);
      idle(1);
      check("to2_run", {bus.sel, bus.run_en}, 3'b001);
      tick();
      check("to_no_load", n_load - base, 0);
      check("to_data_kept", bus.data_out, 16'h0909);

      // Simultaneous keys
      bus.time_in = 24'h123400;
      key(1'b1, 1'b0, 1'b0);
      key(1'b1, 1'b1, 1'b0);
      check("mode_up_sel", bus.sel, 2);
      key(1'b0, 1'b1, 1'b1);
      check("updn_sel", bus.sel, 2);
      check("updn_blink", bus.blink, 1);
      key(1'b1, 1'b0, 1'b0);
      check("simul_commit", {15'd0, bus.load, bus.data_out}, {15'd0, 1'b1, 16'h1234});
      key(1'b1, 1'b0, 1'b0);
      check("commit_key_drop", {bus.sel, bus.run_en, bus.load}, 4'b0010);
      tick();

      // Reset mid-edit
      bus.time_in = 24'h111100;
      key(1'b1, 1'b0, 1'b0);
      key(1'b0, 1'b1, 1'b0);
      key(1'b1, 1'b0, 1'b0);
      key(1'b0, 1'b1, 1'b0);
      check("pre_rst_sel", bus.sel, 2);
      rst = 1'b1;
      bus.key_mode = 1'b1;
      tick();
      check("mid_rst_outs", {bus.sel, bus.run_en, bus.load, bus.blink}, 5'b00100);
      check("mid_rst_data", bus.data_out, 16'h0000);
      rst = 1'b0;
      bus.key_mode = 1'b0;
      tick();
      set_seq("recapture", 24'h050607, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0506);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
